// File: rtl/md_unit.sv
// HI/LO multiply/divide unit for the E stage. It computes the result when the op is accepted.
// It then holds that result for a fixed busy period and only then commits it to HI/LO.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op,
    input  logic        kill,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        rd_sel,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] md_out
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6
    } md_op_e;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [31:0]        tmp_hi_q, tmp_hi_d;
    logic [31:0]        tmp_lo_q, tmp_lo_d;
    logic               tmp_skip_q, tmp_skip_d;
    logic               start;

    logic [63:0]        prod_s, prod_u;
    logic               div_signed;
    logic [31:0]        a_mag, b_mag, div_b, q_mag, r_mag, quot, rem;

    // Sign-extending to 64 bits lets one unsigned multiply give the exact signed product.
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Signed divide runs on magnitudes, then quotient/remainder signs are restored (truncate toward zero).
    always_comb begin
        div_signed = (md_op == OP_DIV);
        a_mag      = (div_signed && A[31]) ? (~A + 32'd1) : A;
        b_mag      = (div_signed && B[31]) ? (~B + 32'd1) : B;
        div_b      = (B == 32'd0) ? 32'd1 : b_mag;
        q_mag      = a_mag / div_b;
        r_mag      = a_mag % div_b;
        quot       = (div_signed && (A[31] ^ B[31])) ? (~q_mag + 32'd1) : q_mag;
        rem        = (div_signed && A[31]) ? (~r_mag + 32'd1) : r_mag;
    end

    // NOTE: every variable below gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        tmp_hi_d   = tmp_hi_q;
        tmp_lo_d   = tmp_lo_q;
        tmp_skip_d = tmp_skip_q;
        start      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!kill) begin
                    case (md_op)
                        OP_MULT, OP_MULTU: begin
                            start      = 1'b1;
                            state_d    = S_BUSY;
                            cnt_d      = CNT_W'(MULT_CYCLES);
                            tmp_skip_d = 1'b0;
                            {tmp_hi_d, tmp_lo_d} = (md_op == OP_MULT) ? prod_s : prod_u;
                        end
                        OP_DIV, OP_DIVU: begin
                            start      = 1'b1;
                            state_d    = S_BUSY;
                            cnt_d      = CNT_W'(DIV_CYCLES);
                            tmp_skip_d = (B == 32'd0);
                            tmp_hi_d   = rem;
                            tmp_lo_d   = quot;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    if (!tmp_skip_q) begin
                        hi_d = tmp_hi_q;
                        lo_d = tmp_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: the temp result registers carry no reset; they are only read after a full busy period that reset aborts.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        tmp_hi_q   <= tmp_hi_d;
        tmp_lo_q   <= tmp_lo_d;
        tmp_skip_q <= tmp_skip_d;
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy     = (state_q == S_BUSY);
    assign md_stall = busy | start;
    assign md_out   = rd_sel ? lo_q : hi_q;

endmodule
